// File: rtl/adam_pause_pkg.sv
// Shared types for the pause/reset responders: target state encoding and
// the drain-counter width helper.
package adam_pause_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        PAUSED = 2'd2
    } pause_tgt_state_t;

    // Counter must hold DRAIN_CYCLES; never narrower than one bit.
    function automatic int cnt_width(input int drain);
        return (drain < 1) ? 1 : $clog2(drain + 1);
    endfunction

endpackage

// File: rtl/adam_apb_xfer_tracker.sv
// Tracks whether an APB transfer has been forwarded downstream and derives
// the forwarded psel/penable; a gated transfer restarts with a fresh setup.
module adam_apb_xfer_tracker (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic slv_psel,
    input  logic mst_pready,
    output logic xfer_open,
    output logic mst_psel,
    output logic mst_penable
);

    // An open transfer is always allowed to finish, regardless of run.
    assign mst_psel    = slv_psel & (run | xfer_open);
    assign mst_penable = mst_psel & xfer_open;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_open <= 1'b0;
        end else if (mst_psel && !mst_penable) begin
            xfer_open <= 1'b1;
        end else if (mst_penable && mst_pready) begin
            xfer_open <= 1'b0;
        end
    end

endmodule

// File: rtl/adam_apb_pause_tgt.sv
// APB target-side pause responder: drains the open transfer, waits
// DRAIN_CYCLES idle cycles, then acks. Optional ADAM_APB_PAUSE_TGT_ERR_EN.
module adam_apb_pause_tgt
    import adam_pause_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pause_req,
    output logic                    pause_ack,
    input  logic                    slv_psel,
    input  logic                    slv_penable,
    input  logic                    slv_pwrite,
    input  logic [ADDR_WIDTH-1:0]   slv_paddr,
    input  logic [DATA_WIDTH-1:0]   slv_pwdata,
    input  logic [DATA_WIDTH/8-1:0] slv_pstrb,
    output logic                    slv_pready,
    output logic                    slv_pslverr,
    output logic [DATA_WIDTH-1:0]   slv_prdata,
    output logic                    mst_psel,
    output logic                    mst_penable,
    output logic                    mst_pwrite,
    output logic [ADDR_WIDTH-1:0]   mst_paddr,
    output logic [DATA_WIDTH-1:0]   mst_pwdata,
    output logic [DATA_WIDTH/8-1:0] mst_pstrb,
    input  logic                    mst_pready,
    input  logic                    mst_pslverr,
    input  logic [DATA_WIDTH-1:0]   mst_prdata
);

    localparam int CW = cnt_width(DRAIN_CYCLES);
    localparam logic [CW-1:0] DRAIN_LD = CW'(DRAIN_CYCLES);

    pause_tgt_state_t state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ack_d;
    logic             xfer_open;
    logic             err_rsp;

    adam_apb_xfer_tracker u_trk (
        .clk         (clk),
        .rst         (rst),
        .run         (state_q == RUN),
        .slv_psel    (slv_psel),
        .mst_pready  (mst_pready),
        .xfer_open   (xfer_open),
        .mst_psel    (mst_psel),
        .mst_penable (mst_penable)
    );

    assign mst_pwrite = slv_pwrite;
    assign mst_paddr  = slv_paddr;
    assign mst_pwdata = slv_pwdata;
    assign mst_pstrb  = slv_pstrb;

`ifdef ADAM_APB_PAUSE_TGT_ERR_EN
    // A fresh access phase while not running is refused locally.
    assign err_rsp = slv_psel & slv_penable & ~xfer_open & (state_q != RUN);
`else
    logic unused_penable;
    assign unused_penable = slv_penable;
    assign err_rsp        = 1'b0;
`endif

    assign slv_pready  = (mst_pready & mst_penable) | err_rsp;
    assign slv_pslverr = (mst_penable & mst_pslverr) | err_rsp;
    assign slv_prdata  = mst_penable ? mst_prdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PAUSED;
            cnt_q     <= '0;
            pause_ack <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pause_ack <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = pause_ack;
        unique case (state_q)
            RUN: begin
                if (pause_req) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_LD;
                end
            end
            DRAIN: begin
                // Idle countdown restarts whenever a transfer is still open.
                if (!pause_req) begin
                    state_d = RUN;
                end else if (xfer_open) begin
                    cnt_d = DRAIN_LD;
                end else if (cnt_q == '0) begin
                    state_d = PAUSED;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            PAUSED: begin
                if (!pause_req) begin
                    state_d = RUN;
                    ack_d   = 1'b0;
                end
            end
            default: state_d = PAUSED;
        endcase
    end

endmodule

// File: tb/tb_adam_apb_pause_tgt.sv
// Scoreboard bench for adam_apb_pause_tgt (DRAIN_CYCLES = 4); fabric-side
// completions are popped against expectations pushed when each access starts.
module tb_adam_apb_pause_tgt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pause_req = 1'b1;
    logic        pause_ack;
    logic        slv_psel = 1'b0, slv_penable = 1'b0, slv_pwrite = 1'b0;
    logic [31:0] slv_paddr = '0, slv_pwdata = '0;
    logic [3:0]  slv_pstrb = '0;
    logic        slv_pready, slv_pslverr;
    logic [31:0] slv_prdata;
    logic        mst_psel, mst_penable, mst_pwrite;
    logic [31:0] mst_paddr, mst_pwdata;
    logic [3:0]  mst_pstrb;
    logic        mst_pready;
    logic        mst_pslverr = 1'b0;
    logic [31:0] mst_prdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    // peripheral model
    int          per_wait = 0;
    int          acc_cnt  = 0;
    int          wr_count = 0;
    logic [31:0] last_wa  = '0;
    logic [31:0] last_wd  = '0;

    always #5 clk = ~clk;

    adam_apb_pause_tgt dut (
        .clk         (clk),
        .rst         (rst),
        .pause_req   (pause_req),
        .pause_ack   (pause_ack),
        .slv_psel    (slv_psel),
        .slv_penable (slv_penable),
        .slv_pwrite  (slv_pwrite),
        .slv_paddr   (slv_paddr),
        .slv_pwdata  (slv_pwdata),
        .slv_pstrb   (slv_pstrb),
        .slv_pready  (slv_pready),
        .slv_pslverr (slv_pslverr),
        .slv_prdata  (slv_prdata),
        .mst_psel    (mst_psel),
        .mst_penable (mst_penable),
        .mst_pwrite  (mst_pwrite),
        .mst_paddr   (mst_paddr),
        .mst_pwdata  (mst_pwdata),
        .mst_pstrb   (mst_pstrb),
        .mst_pready  (mst_pready),
        .mst_pslverr (mst_pslverr),
        .mst_prdata  (mst_prdata)
    );

    function automatic logic [31:0] per_rd(input logic [31:0] a);
        return (a == 32'h20) ? 32'hDEAD_BEEF : ~a;
    endfunction

    assign mst_pready = mst_penable && (acc_cnt >= per_wait);
    assign mst_prdata = per_rd(mst_paddr);

    always @(posedge clk) begin
        if (mst_psel && mst_penable && !mst_pready) acc_cnt <= acc_cnt + 1;
        else                                        acc_cnt <= 0;
        if (mst_psel && mst_penable && mst_pready && mst_pwrite) begin
            wr_count <= wr_count + 1;
            last_wa  <= mst_paddr;
            last_wd  <= mst_pwdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // completion monitor: pop one expectation per fabric-side completion
    always @(negedge clk) begin
        if (!rst && slv_psel && slv_penable && slv_pready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rdata", slv_prdata, e.rdata);
                chk("pslverr", {31'd0, slv_pslverr}, {31'd0, e.err});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive setup now, access phase after the next edge.
    task automatic apb_start(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb.push_back(e);
        slv_psel = 1'b1; slv_penable = 1'b0; slv_pwrite = wr;
        slv_paddr = a; slv_pwdata = d; slv_pstrb = 4'hF;
        tick(1);
        slv_penable = 1'b1;
    endtask

    task automatic apb_wait(input int budget);
        int n = 0;
        @(negedge clk);
        while (!slv_pready && n < budget) begin
            n++;
            @(negedge clk);
        end
        if (!slv_pready) chk("apb_timeout", 32'd0, 32'd1);
        tick(1);
        slv_psel = 1'b0; slv_penable = 1'b0;
    endtask

    task automatic ack_after(input string tag, input int k);
        for (int i = 1; i <= k; i++) begin
            tick(1);
            chk(tag, {31'd0, pause_ack}, {31'd0, (i == k)});
            chk({tag, "_psel"}, {31'd0, mst_psel}, 32'd0);
        end
    endtask

    initial begin
        int w0;
        // reset
        @(negedge clk);
        chk("rst_ack", {31'd0, pause_ack}, 32'd1);
        chk("rst_psel", {31'd0, mst_psel}, 32'd0);
        chk("rst_pready", {31'd0, slv_pready}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("held_ack", {31'd0, pause_ack}, 32'd1);
        pause_req = 1'b0;
        @(negedge clk);
        chk("ack_before_edge", {31'd0, pause_ack}, 32'd1);
        tick(1);
        chk("ack_fall", {31'd0, pause_ack}, 32'd0);

        // idle pause: ack on 6th edge
        pause_req = 1'b1;
        ack_after("idle_ack", 6);
        pause_req = 1'b0;
        tick(1);
        chk("idle_ack_fall", {31'd0, pause_ack}, 32'd0);

        // slow read, req raised mid-transfer
        per_wait = 3;
        apb_start(1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0);
        tick(1);
        pause_req = 1'b1;
        apb_wait(10);
        per_wait = 0;
        ack_after("drain_ack", 5);

        // write while paused stalls, then resumes with one fresh setup
`ifndef ADAM_APB_PAUSE_TGT_ERR_EN
        w0 = wr_count;
        apb_start(1'b1, 32'h10, 32'h55, per_rd(32'h10), 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_psel", {31'd0, mst_psel}, 32'd0);
            chk("stall_pready", {31'd0, slv_pready}, 32'd0);
            tick(1);
        end
        pause_req = 1'b0;
        tick(1);
        @(negedge clk);
        chk("resume_setup_psel", {31'd0, mst_psel}, 32'd1);
        chk("resume_setup_pen", {31'd0, mst_penable}, 32'd0);
        chk("resume_setup_rdy", {31'd0, slv_pready}, 32'd0);
        apb_wait(4);
        tick(3);
        chk("wr_once", wr_count - w0, 32'd1);
        chk("wr_addr", last_wa, 32'h10);
        chk("wr_data", last_wd, 32'h55);
`else
        // refused access while paused
        apb_start(1'b0, 32'h20, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        chk("err_psel", {31'd0, mst_psel}, 32'd0);
        apb_wait(2);
        chk("err_psel_after", {31'd0, mst_psel}, 32'd0);
        pause_req = 1'b0;
        tick(2);
`endif
        chk("run_ack", {31'd0, pause_ack}, 32'd0);

        // short req pulse inside DRAIN: no ack, traffic unaffected
        pause_req = 1'b1;
        tick(2);
        pause_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("pulse_no_ack", {31'd0, pause_ack}, 32'd0);
        end
        w0 = wr_count;
        apb_start(1'b1, 32'h24, 32'hA5A5_0001, per_rd(32'h24), 1'b0);
        apb_wait(1);
        tick(1);
        chk("pulse_wr", wr_count - w0, 32'd1);

        // req and new setup in the same cycle: forwarded, then drained
        apb_start(1'b0, 32'h30, 32'h0, per_rd(32'h30), 1'b0);
        // setup already driven; raise req in the access cycle would be late,
        // so this case raises it together with setup on the next transfer
        apb_wait(2);
        slv_psel = 1'b1; slv_penable = 1'b0; slv_pwrite = 1'b0; slv_paddr = 32'h34;
        begin
            exp_t e;
            e.rdata = per_rd(32'h34);
            e.err   = 1'b0;
            sb.push_back(e);
        end
        pause_req = 1'b1;
        @(negedge clk);
        chk("simul_psel", {31'd0, mst_psel}, 32'd1);
        tick(1);
        slv_penable = 1'b1;
        apb_wait(2);
        ack_after("simul_ack", 5);
        pause_req = 1'b0;
        tick(1);
        chk("simul_ack_fall", {31'd0, pause_ack}, 32'd0);

        tick(2);
        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
